// File: rtl/i2c_byte_engine.sv
// Byte-level I2C master bit engine: START/STOP/TX/RX phases built from four
// quarter-bit steps, open-drain SCL/SDA enables, completion pulses for the sequencer.
module i2c_byte_engine #(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       send,
  input  logic [7:0] datasend,
  input  logic       receive,
  input  logic       nack_in,
  output logic       sended,
  output logic       received,
  output logic [7:0] datareceive,
  output logic       ack_err,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_STOP, S_TX, S_RX, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [3:0]       bit_q, bit_d;
  logic [7:0]       data_q, data_d;
  logic             nack_q, nack_d;
  logic             ack_smp_q, ack_smp_d;
  logic             bus_held_q, bus_held_d;
  logic             busy_q, busy_d;
  logic             sended_q, sended_d;
  logic             received_q, received_d;
  logic [7:0]       datareceive_q, datareceive_d;
  logic             ack_err_q, ack_err_d;
  logic             scl_oe_q, scl_oe_d;
  logic             sda_oe_q, sda_oe_d;

  logic             active;
  logic             tick;
  logic [3:0]       last_bit;
  logic [3:0]       scl_pat;
  logic [3:0]       sda_pat;
  logic [2:0]       tx_idx;

  // Sequencing: quarter counter, phase progress, sampling and completion
  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    qtr_d         = qtr_q;
    bit_d         = bit_q;
    data_d        = data_q;
    nack_d        = nack_q;
    ack_smp_d     = ack_smp_q;
    bus_held_d    = bus_held_q;
    sended_d      = 1'b0;
    received_d    = 1'b0;
    datareceive_d = datareceive_q;
    ack_err_d     = ack_err_q;

    active   = (state_q == S_START) || (state_q == S_STOP) ||
               (state_q == S_TX)    || (state_q == S_RX);
    tick     = active && (cnt_q == CNT_W'(CLK_DIV - 1));
    last_bit = ((state_q == S_TX) || (state_q == S_RX)) ? 4'd8 : 4'd0;

    if (active && !tick) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        qtr_d = 2'd0;
        bit_d = 4'd0;
        if (start) begin
          state_d = S_START;
        end else if (stop) begin
          state_d = S_STOP;
        end else if (send) begin
          state_d = S_TX;
          data_d  = datasend;
        end else if (receive) begin
          state_d = S_RX;
          nack_d  = nack_in;
        end
      end
      S_START, S_STOP, S_TX, S_RX: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd2) begin
            if ((state_q == S_TX) && (bit_q == 4'd8)) begin
              ack_smp_d = sda_in;
            end
            if ((state_q == S_RX) && (bit_q < 4'd8)) begin
              data_d = {data_q[6:0], sda_in};
            end
          end
          if (qtr_q == 2'd3) begin
            if (bit_q == last_bit) begin
              state_d = S_DONE;
              case (state_q)
                S_START: bus_held_d = 1'b1;
                S_STOP:  bus_held_d = 1'b0;
                S_TX: begin
                  sended_d  = 1'b1;
                  ack_err_d = ack_smp_q;
                end
                default: begin
                  received_d    = 1'b1;
                  datareceive_d = data_q;
                end
              endcase
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        qtr_d   = 2'd0;
        bit_d   = 4'd0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Line drive for the quarter being entered; patterns indexed {Q3,Q2,Q1,Q0}
  always_comb begin
    scl_pat  = 4'b0000;
    sda_pat  = 4'b0000;
    tx_idx   = 3'(4'd7 - bit_d);
    scl_oe_d = scl_oe_q;
    sda_oe_d = sda_oe_q;
    case (state_d)
      S_START: begin
        scl_pat = bus_held_q ? 4'b1001 : 4'b1000;
        sda_pat = bus_held_q ? 4'b1100 : 4'b1110;
      end
      S_STOP: begin
        scl_pat = 4'b0001;
        sda_pat = 4'b0011;
      end
      S_TX: begin
        scl_pat = 4'b1001;
        sda_pat = (bit_d < 4'd8) ? {4{~data_d[tx_idx]}} : 4'b0000;
      end
      S_RX: begin
        scl_pat = 4'b1001;
        sda_pat = (bit_d < 4'd8) ? 4'b0000 : {4{~nack_d}};
      end
      default: ;
    endcase
    if ((state_d != S_IDLE) && (state_d != S_DONE)) begin
      scl_oe_d = scl_pat[qtr_d];
      sda_oe_d = sda_pat[qtr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      qtr_q         <= 2'd0;
      bit_q         <= 4'd0;
      data_q        <= 8'h00;
      nack_q        <= 1'b0;
      ack_smp_q     <= 1'b0;
      bus_held_q    <= 1'b0;
      busy_q        <= 1'b0;
      sended_q      <= 1'b0;
      received_q    <= 1'b0;
      datareceive_q <= 8'h00;
      ack_err_q     <= 1'b0;
      scl_oe_q      <= 1'b0;
      sda_oe_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      qtr_q         <= qtr_d;
      bit_q         <= bit_d;
      data_q        <= data_d;
      nack_q        <= nack_d;
      ack_smp_q     <= ack_smp_d;
      bus_held_q    <= bus_held_d;
      busy_q        <= busy_d;
      sended_q      <= sended_d;
      received_q    <= received_d;
      datareceive_q <= datareceive_d;
      ack_err_q     <= ack_err_d;
      scl_oe_q      <= scl_oe_d;
      sda_oe_q      <= sda_oe_d;
    end
  end

  assign sended      = sended_q;
  assign received    = received_q;
  assign datareceive = datareceive_q;
  assign ack_err     = ack_err_q;
  assign busy        = busy_q;
  assign scl_oe      = scl_oe_q;
  assign sda_oe      = sda_oe_q;

endmodule

// File: tb/tb_i2c_byte_engine.sv
// Directed bench for i2c_byte_engine (CLK_DIV=4): open-drain SDA with a scripted
// slave, per-phase cycle tracing, immediate-assertion checks.
module tb_i2c_byte_engine;

  logic       clk = 1'b0;
  logic       reset, start, stop, send, receive, nack_in;
  logic [7:0] datasend;
  logic       sended, received, ack_err, busy, scl_oe, sda_oe, sda_in;
  logic [7:0] datareceive;
  logic       slave_pull;

  int checks   = 0;
  int failures = 0;

  int          busy_cnt, s_cnt, s_cyc, r_cnt, r_cyc, stable_err, nack_viol, rises, quiet;
  logic [15:0] bits;
  logic [63:0] sda_tr, scl_tr;
  logic        timed_out;

  i2c_byte_engine #(.CLK_DIV(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .send(send),
    .datasend(datasend), .receive(receive), .nack_in(nack_in),
    .sended(sended), .received(received), .datareceive(datareceive),
    .ack_err(ack_err), .busy(busy), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .sda_in(sda_in)
  );

  assign sda_in = ~(sda_oe | slave_pull);

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse one command in the current cycle; returns in cycle 1 of the phase
  task automatic issue(input logic st, input logic sp, input logic sd, input logic rc,
                       input logic [7:0] d, input logic nk);
    start = st; stop = sp; send = sd; receive = rc; datasend = d; nack_in = nk;
    @(posedge clk); #1;
    start = 0; stop = 0; send = 0; receive = 0;
  endtask

  // mode 0: slave passive, 1: slave ACKs bit 9, 2: slave drives rx_byte
  task automatic observe(input int mode, input logic [7:0] rx_byte,
                         input int inject_at, input int reset_at);
    logic prev_scl, last_sda;
    busy_cnt = 0; s_cnt = 0; s_cyc = 0; r_cnt = 0; r_cyc = 0;
    stable_err = 0; nack_viol = 0; rises = 0; bits = '0;
    sda_tr = '0; scl_tr = '0; timed_out = 1'b1;
    prev_scl = scl_oe; last_sda = sda_in;
    for (int k = 1; k <= 200; k++) begin
      if (k == reset_at + 1) reset = 1'b0;
      if (k == reset_at) reset = 1'b1;
      send = (k == inject_at);
      if (k == inject_at) datasend = 8'hFF;
      case (mode)
        1: slave_pull = (k >= 129) && (k <= 144);
        2: slave_pull = (k <= 128) ? ~rx_byte[3'(7 - (k - 1) / 16)] : 1'b0;
        default: slave_pull = 1'b0;
      endcase
      #1;
      if (k < 64) begin
        sda_tr[k] = sda_oe;
        scl_tr[k] = scl_oe;
      end
      if (sended) begin s_cnt++; s_cyc = k; end
      if (received) begin r_cnt++; r_cyc = k; end
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      busy_cnt++;
      if (prev_scl && !scl_oe) begin
        bits = {bits[14:0], sda_in};
        last_sda = sda_in;
        rises++;
      end else if (!prev_scl && !scl_oe && (sda_in != last_sda)) begin
        stable_err++;
      end
      if ((mode == 2) && (k >= 129) && (k <= 144) && sda_oe) nack_viol++;
      prev_scl = scl_oe;
      @(posedge clk); #1;
    end
    send = 1'b0;
    slave_pull = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1; start = 0; stop = 0; send = 0; receive = 0;
    nack_in = 0; datasend = 8'h00; slave_pull = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    chk("reset_outputs", {18'd0, scl_oe, sda_oe, busy, sended, received, ack_err, datareceive}, 32'h0);
    @(posedge clk); #1;
    chk("idle_after_reset", {29'd0, busy, scl_oe, sda_oe}, 32'h0);

    // START on a free bus
    issue(1, 0, 0, 0, 8'h00, 0);
    observe(0, 8'h00, 0, 0);
    chk("start_timeout", 32'(timed_out), 32'd0);
    chk("start_busy_cycles", busy_cnt, 32'd17);
    chk("start_sda_trace", 32'(sda_tr[16:1]), 32'h0000_FFF0);
    chk("start_scl_trace", 32'(scl_tr[16:1]), 32'h0000_F000);
    chk("start_bus_held_lines", {30'd0, scl_oe, sda_oe}, 32'h3);

    // TX 0xEE with slave ACK
    issue(0, 0, 1, 0, 8'hEE, 0);
    observe(1, 8'h00, 0, 0);
    chk("tx_ee_timeout", 32'(timed_out), 32'd0);
    chk("tx_ee_sended_cycle", s_cyc, 32'd145);
    chk("tx_ee_sended_count", s_cnt, 32'd1);
    chk("tx_ee_busy_cycles", busy_cnt, 32'd145);
    chk("tx_ee_scl_rises", rises, 32'd9);
    chk("tx_ee_line_bits", 32'(bits[8:0]), 32'h1DC);
    chk("tx_ee_sda_stable", stable_err, 32'd0);
    chk("tx_ee_ack_err", 32'(ack_err), 32'd0);

    // TX 0xEF, slave leaves SDA released on ACK
    issue(0, 0, 1, 0, 8'hEF, 0);
    observe(0, 8'h00, 0, 0);
    chk("tx_ef_sended_cycle", s_cyc, 32'd145);
    chk("tx_ef_line_bits", 32'(bits[8:0]), 32'h1DF);
    chk("tx_ef_ack_err", 32'(ack_err), 32'd1);

    // RX with NACK, slave drives 0x55
    issue(0, 0, 0, 1, 8'h00, 1);
    observe(2, 8'h55, 0, 0);
    chk("rx_received_cycle", r_cyc, 32'd145);
    chk("rx_pulse_counts", {r_cnt[15:0], s_cnt[15:0]}, 32'h0001_0000);
    chk("rx_datareceive", 32'(datareceive), 32'h55);
    chk("rx_line_bits", 32'(bits[8:0]), 32'h0AB);
    chk("rx_master_nack_release", nack_viol, 32'd0);
    chk("rx_sda_stable", stable_err, 32'd0);

    // send+receive together: TX wins; extra send mid-phase is ignored
    issue(0, 0, 1, 1, 8'h3C, 0);
    observe(1, 8'h00, 20, 0);
    chk("prio_sended_count", s_cnt, 32'd1);
    chk("prio_received_count", r_cnt, 32'd0);
    chk("prio_busy_cycles", busy_cnt, 32'd145);
    chk("prio_line_bits", 32'(bits[8:0]), 32'h078);
    chk("prio_datareceive_held", 32'(datareceive), 32'h55);
    chk("prio_ack_err", 32'(ack_err), 32'd0);

    // reset during TX bit 4 (cycles 65..80)
    issue(0, 0, 1, 0, 8'hA5, 0);
    observe(0, 8'h00, 0, 70);
    chk("rst_busy_cycles", busy_cnt, 32'd70);
    chk("rst_lines_released", {29'd0, busy, scl_oe, sda_oe}, 32'h0);
    chk("rst_no_sended", s_cnt, 32'd0);
    chk("rst_regs_cleared", {23'd0, ack_err, datareceive}, 32'h0);
    quiet = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (sended || received || busy) quiet++;
    end
    chk("rst_stays_quiet", quiet, 32'd0);

    // STOP without a held bus still runs the sequence
    issue(0, 1, 0, 0, 8'h00, 0);
    observe(0, 8'h00, 0, 0);
    chk("stop_timeout", 32'(timed_out), 32'd0);
    chk("stop_busy_cycles", busy_cnt, 32'd17);
    chk("stop_sda_trace", 32'(sda_tr[16:1]), 32'h0000_00FF);
    chk("stop_scl_trace", 32'(scl_tr[16:1]), 32'h0000_000F);
    chk("stop_bus_released", {30'd0, scl_oe, sda_oe}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
